// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front-end conditioning for the four player buttons feeding the game core.
// Each raw pad input is synchronised into the clk_12MHz domain with a 2-flop
// chain, debounced with a per-channel hold counter, and turned into
// single-cycle action pulses. Left and right additionally auto-repeat while
// held, after a mutual-exclusion arbitration so that holding both yields no
// movement.
//
// Parameters:
//   DEBOUNCE_CYCLES : cycles a new synchronised level must persist
//   REPEAT_DELAY    : cycles from first left/right pulse to first repeat
//   REPEAT_PERIOD   : cycles between subsequent repeat pulses
//   CNT_W           : counter width, 2**CNT_W must exceed every count above
//
// Ports:
//   clk_12MHz        in  system clock
//   reset            in  asynchronous active-low reset
//   btn_*_raw        in  asynchronous pad inputs, active-high
//   left/right       out single-cycle movement pulses (with auto-repeat)
//   shoot/start      out single-cycle pulses on press
//   left_level       out debounced left level (not arbitrated)
//   right_level      out debounced right level (not arbitrated)
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_DELAY    = 3000000,
    parameter int REPEAT_PERIOD   = 600000,
    parameter int CNT_W           = 22
) (
    input  logic clk_12MHz,
    input  logic reset,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic btn_shoot_raw,
    input  logic btn_start_raw,
    output logic left,
    output logic right,
    output logic shoot,
    output logic start,
    output logic left_level,
    output logic right_level
);

    // Channel indices into the packed per-channel vectors.
    localparam int NCH  = 4;
    localparam int CH_L = 0;
    localparam int CH_R = 1;
    localparam int CH_S = 2;
    localparam int CH_T = 3;

    // Terminal counts, precomputed at the counter width.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] meta_q;
    logic [NCH-1:0] meta_d;
    logic [NCH-1:0] sync_q;
    logic [NCH-1:0] sync_d;

    assign raw_s = {btn_start_raw, btn_shoot_raw, btn_right_raw, btn_left_raw};

    // Next state of the two synchroniser stages.
    always_comb begin
        meta_d = raw_s;
        sync_d = meta_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            meta_q <= 4'b0000;
            sync_q <= 4'b0000;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: a channel's accepted level only moves after the synchronised
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive edges; any
    // agreement in between restarts the count.
    // -------------------------------------------------------------------------
    logic [NCH-1:0]            stable_q;
    logic [NCH-1:0]            stable_d;
    logic [NCH-1:0][CNT_W-1:0] db_cnt_q;
    logic [NCH-1:0][CNT_W-1:0] db_cnt_d;

    // Per-channel debounce counter and accepted level.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Debounce state flops.
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            stable_q <= 4'b0000;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shoot / start: one pulse per accepted rising level, nothing on release.
    // -------------------------------------------------------------------------
    logic [1:0] stable_dly_q;
    logic [1:0] stable_dly_d;
    logic       shoot_q;
    logic       shoot_d;
    logic       start_q;
    logic       start_d;

    // Rising-edge detection on the debounced shoot and start levels.
    always_comb begin
        stable_dly_d = {stable_q[CH_T], stable_q[CH_S]};
        shoot_d      = stable_q[CH_S] & ~stable_dly_q[0];
        start_d      = stable_q[CH_T] & ~stable_dly_q[1];
    end

    // Edge-detector history and registered shoot/start pulses.
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            stable_dly_q <= 2'b00;
            shoot_q      <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            stable_dly_q <= stable_dly_d;
            shoot_q      <= shoot_d;
            start_q      <= start_d;
        end
    end

    // -------------------------------------------------------------------------
    // Left/right arbitration and auto-repeat.
    // Holding both directions cancels both; releasing one makes the survivor's
    // effective input rise, which the FSM treats as a fresh press.
    // -------------------------------------------------------------------------
    logic [1:0] eff_s;
    logic [1:0] rpt_pulse_s;

    assign eff_s[0] = stable_q[CH_L] & ~stable_q[CH_R];
    assign eff_s[1] = stable_q[CH_R] & ~stable_q[CH_L];

    for (genvar g = 0; g < 2; g++) begin : g_rpt
        rpt_state_e       state_q;
        rpt_state_e       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pulse_q;
        logic             pulse_d;

        // Repeat FSM next state. Any state other than IDLE implies eff was
        // high on the previous edge, so eff high while IDLE is a rising edge.
        // A low eff wins over a terminal count and emits nothing.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            if (!eff_s[g]) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (cnt_q == RD_LAST) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_REPEAT;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (cnt_q == RP_LAST) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // Repeat FSM state, counter and registered pulse.
        always_ff @(posedge clk_12MHz or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        assign rpt_pulse_s[g] = pulse_q;
    end

    // -------------------------------------------------------------------------
    // Outputs: every one is a flop output.
    // -------------------------------------------------------------------------
    assign left        = rpt_pulse_s[0];
    assign right       = rpt_pulse_s[1];
    assign shoot       = shoot_q;
    assign start       = start_q;
    assign left_level  = stable_q[CH_L];
    assign right_level = stable_q[CH_R];

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// Self-checking bench for input_conditioner with short timing parameters.
// The reference model describes the behaviour in terms of a sliding window of
// synchronised samples (a level is accepted once the last DEBOUNCE samples all
// disagree with it) and of the elapsed length of each effective-press run
// (pulses at run offsets 0, RD, RD+RP, RD+2RP, ...).
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk_12MHz = 1'b0;
    logic reset     = 1'b0;
    logic btn_left_raw  = 1'b0;
    logic btn_right_raw = 1'b0;
    logic btn_shoot_raw = 1'b0;
    logic btn_start_raw = 1'b0;
    logic left, right, shoot, start, left_level, right_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_12MHz = ~clk_12MHz;

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (22)
    ) dut (
        .clk_12MHz     (clk_12MHz),
        .reset         (reset),
        .btn_left_raw  (btn_left_raw),
        .btn_right_raw (btn_right_raw),
        .btn_shoot_raw (btn_shoot_raw),
        .btn_start_raw (btn_start_raw),
        .left          (left),
        .right         (right),
        .shoot         (shoot),
        .start         (start),
        .left_level    (left_level),
        .right_level   (right_level)
    );

    // ------------------------------------------------------------------ model
    logic [3:0]        m_s1, m_s2, m_stable, m_prev;
    logic [3:0][D-1:0] m_hist;
    int                m_run_l, m_run_r;
    logic              m_left, m_right, m_shoot, m_start;
    logic              m_eff_l, m_eff_r;
    logic [5:0]        obs_s, exp_s;

    assign m_eff_l = m_stable[0] & ~m_stable[1];
    assign m_eff_r = m_stable[1] & ~m_stable[0];
    assign obs_s   = {left, right, shoot, start, left_level, right_level};
    assign exp_s   = {m_left, m_right, m_shoot, m_start, m_stable[0], m_stable[1]};

    function automatic logic [3:0][D-1:0] hist_next(input logic [3:0][D-1:0] h,
                                                    input logic [3:0] s);
        logic [3:0][D-1:0] r;
        for (int c = 0; c < 4; c++) r[c] = {h[c][D-2:0], s[c]};
        return r;
    endfunction

    function automatic logic [3:0] stable_next(input logic [3:0][D-1:0] h,
                                               input logic [3:0] s,
                                               input logic [3:0] st);
        logic [3:0]   r;
        logic [D-1:0] win;
        r = st;
        for (int c = 0; c < 4; c++) begin
            win = {h[c][D-2:0], s[c]};
            if (win == {D{~st[c]}}) r[c] = ~st[c];
        end
        return r;
    endfunction

    function automatic logic rpt_due(input int k);
        return (k == 0) || (k == RD) || ((k > RD) && (((k - RD) % RP) == 0));
    endfunction

    always @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            m_s1 <= 4'b0; m_s2 <= 4'b0; m_stable <= 4'b0; m_prev <= 4'b0;
            m_hist <= '0; m_run_l <= 0; m_run_r <= 0;
            m_left <= 1'b0; m_right <= 1'b0; m_shoot <= 1'b0; m_start <= 1'b0;
        end else begin
            m_s1     <= {btn_start_raw, btn_shoot_raw, btn_right_raw, btn_left_raw};
            m_s2     <= m_s1;
            m_hist   <= hist_next(m_hist, m_s2);
            m_stable <= stable_next(m_hist, m_s2, m_stable);
            m_prev   <= m_stable;
            m_shoot  <= m_stable[2] & ~m_prev[2];
            m_start  <= m_stable[3] & ~m_prev[3];
            m_left   <= m_eff_l && rpt_due(m_run_l);
            m_run_l  <= m_eff_l ? m_run_l + 1 : 0;
            m_right  <= m_eff_r && rpt_due(m_run_r);
            m_run_r  <= m_eff_r ? m_run_r + 1 : 0;
        end
    end

    // ------------------------------------------------------------------ tests
    task automatic settle();
        {btn_start_raw, btn_shoot_raw, btn_right_raw, btn_left_raw} = 4'b0000;
        repeat (14) @(negedge clk_12MHz);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {btn_start_raw, btn_shoot_raw, btn_right_raw, btn_left_raw} = 4'b1111;
        repeat (3) begin
            @(negedge clk_12MHz);
            n_checks++;
            if (obs_s !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_hold got=%b exp=%b", obs_s, 6'b000000);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_12MHz);
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL reset_model c=%0d got=%b exp=%b", c, obs_s, exp_s);
            end
            n_checks++;
            if ({shoot, start} !== ((c == 6) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL reset_pulse c=%0d got=%b exp=%b", c, {shoot, start},
                         ((c == 6) ? 2'b11 : 2'b00));
            end
        end
    endtask

    task automatic test_glitch();
        int cnt;
        settle();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            btn_shoot_raw = (c < 3);
            @(negedge clk_12MHz);
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL glitch_model c=%0d got=%b exp=%b", c, obs_s, exp_s);
            end
            if (shoot) cnt++;
        end
        n_checks++;
        if (cnt !== 0) begin
            n_fail++;
            $display("FAIL glitch_short pulses got=%0d exp=0", cnt);
        end
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            btn_shoot_raw = (c < 6);
            @(negedge clk_12MHz);
            n_checks++;
            if (shoot !== (c == 6)) begin
                n_fail++;
                $display("FAIL glitch_long c=%0d got=%b exp=%b", c, shoot, (c == 6));
            end
            if (shoot) cnt++;
        end
        n_checks++;
        if (cnt !== 1) begin
            n_fail++;
            $display("FAIL glitch_long_count pulses got=%0d exp=1", cnt);
        end
    endtask

    task automatic test_auto_repeat();
        logic exp_r, exp_lvl;
        settle();
        for (int c = 0; c < 90; c++) begin
            btn_right_raw = (c < 60);
            @(negedge clk_12MHz);
            exp_r   = (c == 6) || ((c >= 26) && (c <= 58) && (((c - 26) % 8) == 0));
            exp_lvl = (c >= 5) && (c <= 64);
            n_checks++;
            if ({left, right, right_level} !== {1'b0, exp_r, exp_lvl}) begin
                n_fail++;
                $display("FAIL auto_repeat c=%0d got=%b exp=%b", c,
                         {left, right, right_level}, {1'b0, exp_r, exp_lvl});
            end
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL auto_model c=%0d got=%b exp=%b", c, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_arbitration();
        logic exp_l, exp_r, exp_ll, exp_rl;
        settle();
        for (int c = 0; c < 110; c++) begin
            btn_left_raw  = (c < 50);
            btn_right_raw = (c >= 30) && (c < 90);
            @(negedge clk_12MHz);
            exp_l  = (c == 6) || (c == 26) || (c == 34);
            exp_r  = (c == 56) || (c == 76) || (c == 84) || (c == 92);
            exp_ll = (c >= 5) && (c <= 54);
            exp_rl = (c >= 35) && (c <= 94);
            n_checks++;
            if ({left, right, left_level, right_level} !== {exp_l, exp_r, exp_ll, exp_rl}) begin
                n_fail++;
                $display("FAIL arbitration c=%0d got=%b exp=%b", c,
                         {left, right, left_level, right_level}, {exp_l, exp_r, exp_ll, exp_rl});
            end
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL arb_model c=%0d got=%b exp=%b", c, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_release_terminal();
        logic exp_r;
        settle();
        // Release at 36: level drops after edge 41, when the repeat counter
        // would hit its terminal count and otherwise pulse on edge 42.
        for (int c = 0; c < 80; c++) begin
            btn_right_raw = (c < 36) || (c >= 60);
            @(negedge clk_12MHz);
            exp_r = (c == 6) || (c == 26) || (c == 34) || (c == 66);
            n_checks++;
            if (right !== exp_r) begin
                n_fail++;
                $display("FAIL release_terminal c=%0d got=%b exp=%b", c, right, exp_r);
            end
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL terminal_model c=%0d got=%b exp=%b", c, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic exp_r;
        settle();
        btn_right_raw = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_12MHz);
            exp_r = (c == 6) || (c == 26) || (c == 34);
            n_checks++;
            if (right !== exp_r) begin
                n_fail++;
                $display("FAIL mid_pre c=%0d got=%b exp=%b", c, right, exp_r);
            end
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs_s !== 6'b000000) begin
            n_fail++;
            $display("FAIL mid_reset_async got=%b exp=%b", obs_s, 6'b000000);
        end
        @(negedge clk_12MHz);
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_12MHz);
            exp_r = (c == 6) || (c == 26);
            n_checks++;
            if (right !== exp_r) begin
                n_fail++;
                $display("FAIL mid_post c=%0d got=%b exp=%b", c, right, exp_r);
            end
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL mid_model c=%0d got=%b exp=%b", c, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_random();
        int         hold [4];
        logic [3:0] rv;
        rv = 4'b0000;
        for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (hold[ch] == 0) begin
                    rv[ch]   = ~rv[ch];
                    hold[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                           : int'($urandom_range(6, 45));
                end else begin
                    hold[ch] = hold[ch] - 1;
                end
            end
            {btn_start_raw, btn_shoot_raw, btn_right_raw, btn_left_raw} = rv;
            if (i == 1500) reset = 1'b0;
            if (i == 1503) reset = 1'b1;
            @(negedge clk_12MHz);
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL random_model i=%0d got=%b exp=%b", i, obs_s, exp_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_auto_repeat();
        test_arbitration();
        test_release_terminal();
        test_reset_mid_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage for the four player buttons. It sits directly upstream of `space_invaders_top` and drives that block's `left`, `right`, `shoot` and `start` inputs. Each raw pad signal is synchronised into the `clk_12MHz` domain, debounced, and converted into single-cycle action pulses. Left and right also auto-repeat while held, so the cannon keeps moving.

## Interface
- `DEBOUNCE_CYCLES`, default 120000: cycles the synchronised input must hold a new level before it is accepted (10 ms at 12 MHz).
- `REPEAT_DELAY`, default 3000000: cycles from the first left/right pulse to the first repeat pulse (250 ms).
- `REPEAT_PERIOD`, default 600000: cycles between subsequent repeat pulses (50 ms).
- `CNT_W`, default 22: counter width. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports (clock and reset first):
- `clk_12MHz` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `btn_left_raw`, `btn_right_raw`, `btn_shoot_raw`, `btn_start_raw` in 1 each: asynchronous pad inputs, active-high.
- `left`, `right`, `shoot`, `start` out 1 each: single-cycle action pulses.
- `left_level`, `right_level` out 1 each: debounced held level, used by the game for status.

## Operation
- **Synchroniser:** 2-flop per channel. Reset value 0.
- **Debounce, per channel:**
  - Holds `stable` and a `CNT_W` counter.
  - If `sync != stable`, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 with `sync` still differing, `stable` takes `sync` and the counter clears.
  - If `sync == stable`, the counter clears. Any glitch shorter than DEBOUNCE_CYCLES is therefore ignored.
- **Shoot / start:** one pulse per `stable` 0→1 transition. No repeat, nothing on release.
- **Left/right arbitration:**
  - `eff_l = stable_l & ~stable_r` and `eff_r = stable_r & ~stable_l`.
  - Both held means both effective inputs are 0.
  - When one button is released while the other is still held, the survivor sees `eff` rise and is treated as a fresh press.
- **Left/right repeat FSM, per direction:** states IDLE, DELAY, REPEAT, with a shared-width counter per direction.
  - IDLE: on `eff` rising, emit a pulse, clear the counter, go to DELAY.
  - DELAY: the counter increments. At REPEAT_DELAY-1, emit a pulse, clear the counter, go to REPEAT.
  - REPEAT: the counter increments. At REPEAT_PERIOD-1, emit a pulse and clear the counter.
  - Any state: `eff` = 0 forces IDLE with the counter cleared. No pulse is emitted in that cycle, and this takes priority over a terminal count.
- **Level outputs:** `left_level` = `stable_l`, `right_level` = `stable_r`. They are not arbitrated.
- **Outputs are registered:** all outputs come straight from flops, with no combinational path from inputs to outputs.

## Timing
- **Reset values:** every output, synchroniser flop, `stable` and counter resets to 0, and both FSMs reset to IDLE.
- **Reset mid-operation:** all state clears immediately, even mid-debounce or mid-repeat.
  - A button held through reset release is seen as a new press after the full debounce latency.
- **Press latency:**
  - Raw rises before clock edge 0.
  - `sync` = 1 after edge 1.
  - `stable` = 1 after edge 1+DEBOUNCE_CYCLES.
  - Action pulse high for exactly the cycle after edge 2+DEBOUNCE_CYCLES.
- **Release latency:** `stable` falls DEBOUNCE_CYCLES+1 edges after the raw input falls. The FSM enters IDLE on the following edge.
- **Repeat spacing:**
  - The first repeat pulse comes exactly REPEAT_DELAY cycles after the first pulse.
  - Later pulses come every REPEAT_PERIOD cycles.
  - Pulse width is always 1 cycle; there are never back-to-back pulses with the default parameters.
- **Simultaneous presses:**
  - All four channels are independent apart from the left/right arbitration.
  - Shoot and start may pulse in the same cycle as each other and as left or right.
  - Left and right debounced high on the same edge produce no left/right pulses.

## Test plan
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.

- **Reset:** hold `reset`=0 with all raw inputs at 1, then release. All outputs are 0 during reset. `shoot`/`start` pulse once, 7 edges after reset release (sync 2 + debounce 4 + output 1).
- **Glitch rejection:** raw shoot high for 3 cycles, then low → `shoot` never asserts and `stable` stays 0. Held 6 cycles → exactly one `shoot` pulse.
- **Auto-repeat:** `btn_right_raw` held for 60 cycles → `right` pulses at t0, t0+20, t0+28, t0+36 … and stops within 6 cycles of release. `left` stays 0 throughout.
- **Arbitration:**
  - Press left; 30 cycles later also press right. Left pulses stop, right never pulses, both levels read 1.
  - Release left. `right` pulses once about 6 cycles later, then repeats after 20 cycles.
- **Release at terminal count:** release right so that `eff_r` falls in the same cycle the REPEAT counter reaches 7 → no pulse, and the FSM is in IDLE.
- **Reset mid-repeat:** assert `reset` while in REPEAT → `right`=0 immediately and the FSM is in IDLE. After release with the button still held, one fresh pulse follows after 7 edges.
